// File: rtl/park_pkg.sv
// Shared types and default timing constants for the park gate front end.
package park_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        CHECK,
        OPEN,
        REPORT,
        HOLD,
        DENIED
    } lane_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_OPEN_CYCLES     = 16;

endpackage

// File: rtl/park_gate_lane.sv
// One barrier lane: sensor synchronisers, loop debounce, optional vacancy check,
// barrier timing and a single completion pulse per car.
module park_gate_lane
    import park_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int OPEN_CYCLES     = DEFAULT_OPEN_CYCLES,
    parameter bit HAS_CHECK       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sensor_raw,
    input  logic        is_uni_raw,
    input  logic        pass_raw,
    input  logic        uni_vacant,
    input  logic        gen_vacant,
    input  logic        stall,
    output lane_state_t state,
    output logic        car_pulse,
    output logic        is_uni
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int OTW = $clog2(OPEN_CYCLES) + 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DBW-1:0] DB_MAX  = DBW'(DEBOUNCE_CYCLES);
    localparam logic [OTW-1:0] OT_LAST = OTW'(OPEN_CYCLES - 1);
    localparam logic [OTW-1:0] OT_MAX  = OTW'(OPEN_CYCLES);

    lane_state_t    state_q, state_d;
    logic           sens_s1_q, sens_s1_d, sens_s2_q, sens_s2_d;
    logic           pass_s1_q, pass_s1_d, pass_s2_q, pass_s2_d, pass_s3_q, pass_s3_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic [OTW-1:0] open_tmr_q, open_tmr_d;
    logic           uni_latch_q, uni_latch_d;
    logic           is_uni_q, is_uni_d;
    logic           pass_rise;
    logic           vacant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sens_s1_q   <= 1'b0;
            sens_s2_q   <= 1'b0;
            pass_s1_q   <= 1'b0;
            pass_s2_q   <= 1'b0;
            pass_s3_q   <= 1'b0;
            db_cnt_q    <= '0;
            open_tmr_q  <= '0;
            uni_latch_q <= 1'b0;
            is_uni_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sens_s1_q   <= sens_s1_d;
            sens_s2_q   <= sens_s2_d;
            pass_s1_q   <= pass_s1_d;
            pass_s2_q   <= pass_s2_d;
            pass_s3_q   <= pass_s3_d;
            db_cnt_q    <= db_cnt_d;
            open_tmr_q  <= open_tmr_d;
            uni_latch_q <= uni_latch_d;
            is_uni_q    <= is_uni_d;
        end
    end

    always_comb begin
        sens_s1_d   = sensor_raw;
        sens_s2_d   = sens_s1_q;
        pass_s1_d   = pass_raw;
        pass_s2_d   = pass_s1_q;
        pass_s3_d   = pass_s2_q;
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        open_tmr_d  = open_tmr_q;
        uni_latch_d = uni_latch_q;
        is_uni_d    = is_uni_q;
        pass_rise   = pass_s2_q & ~pass_s3_q;
        vacant      = uni_latch_q ? uni_vacant : gen_vacant;

        case (state_q)
            IDLE: begin
                if (sens_s2_q) begin
                    state_d  = DEBOUNCE;
                    db_cnt_d = DBW'(1);
                end
            end
            DEBOUNCE: begin
                if (!sens_s2_q) begin
                    state_d = IDLE;
                end else begin
                    if (db_cnt_q != DB_MAX) begin
                        db_cnt_d = db_cnt_q + DBW'(1);
                    end
                    // The badge is captured once here; later badge changes never reach the outputs.
                    if (db_cnt_q == DB_LAST) begin
                        uni_latch_d = is_uni_raw;
                        if (HAS_CHECK) begin
                            state_d = CHECK;
                        end else begin
                            state_d    = OPEN;
                            open_tmr_d = '0;
                            is_uni_d   = is_uni_raw;
                        end
                    end
                end
            end
            CHECK: begin
                if (vacant) begin
                    state_d    = OPEN;
                    open_tmr_d = '0;
                    is_uni_d   = uni_latch_q;
                end else begin
                    state_d = DENIED;
                end
            end
            OPEN: begin
                if (pass_rise) begin
                    state_d = REPORT;
                end else if (open_tmr_q == OT_LAST) begin
                    state_d = HOLD;
                end else if (open_tmr_q != OT_MAX) begin
                    open_tmr_d = open_tmr_q + OTW'(1);
                end
            end
            REPORT: begin
                if (!stall) begin
                    state_d = HOLD;
                end
            end
            HOLD, DENIED: begin
                if (!sens_s2_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        state     = state_q;
        car_pulse = (state_q == REPORT) && !stall;
        is_uni    = is_uni_q;
    end

endmodule

// File: rtl/park_gate_ctrl.sv
// Park gate front end: entry lane (with vacancy check) and exit lane, with the
// exit lane winning when both lanes want to report a car in the same cycle.
module park_gate_ctrl
    import park_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int OPEN_CYCLES     = DEFAULT_OPEN_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic entry_sensor,
    input  logic entry_is_uni,
    input  logic entry_pass,
    input  logic exit_sensor,
    input  logic exit_is_uni,
    input  logic exit_pass,
    input  logic uni_is_vacated_space,
    input  logic is_vacated_space,
    output logic car_entered,
    output logic is_uni_car_entered,
    output logic car_exited,
    output logic is_uni_car_exited,
    output logic entry_gate_open,
    output logic exit_gate_open,
    output logic entry_denied
);

    lane_state_t entry_state;
    lane_state_t exit_state;
    logic        entry_stall;

    assign entry_stall = (exit_state == REPORT);

    park_gate_lane #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .OPEN_CYCLES     (OPEN_CYCLES),
        .HAS_CHECK       (1'b1)
    ) u_entry_lane (
        .clk        (clk),
        .rst        (rst),
        .sensor_raw (entry_sensor),
        .is_uni_raw (entry_is_uni),
        .pass_raw   (entry_pass),
        .uni_vacant (uni_is_vacated_space),
        .gen_vacant (is_vacated_space),
        .stall      (entry_stall),
        .state      (entry_state),
        .car_pulse  (car_entered),
        .is_uni     (is_uni_car_entered)
    );

    // Exits never wait on vacancy, so the check inputs are tied and the lane never stalls.
    park_gate_lane #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .OPEN_CYCLES     (OPEN_CYCLES),
        .HAS_CHECK       (1'b0)
    ) u_exit_lane (
        .clk        (clk),
        .rst        (rst),
        .sensor_raw (exit_sensor),
        .is_uni_raw (exit_is_uni),
        .pass_raw   (exit_pass),
        .uni_vacant (1'b1),
        .gen_vacant (1'b1),
        .stall      (1'b0),
        .state      (exit_state),
        .car_pulse  (car_exited),
        .is_uni     (is_uni_car_exited)
    );

    always_comb begin
        entry_gate_open = (entry_state == OPEN);
        exit_gate_open  = (exit_state == OPEN);
        entry_denied    = (entry_state == DENIED);
    end

endmodule

// File: doc/park_gate_ctrl.md
Name: park_gate_ctrl

Overview:
- Upstream front end of the park occupancy counter.
- Turns raw entry/exit loop sensors, badge readers and barrier pass sensors into clean single events on car_entered / car_exited, with the uni flags valid around each event.
- Runs one barrier FSM per lane and refuses entry when park reports no vacancy for the requested class.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synced-high cycles before a loop detection is accepted.
- OPEN_CYCLES, 16: maximum cycles the barrier stays open waiting for the pass sensor.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- entry_sensor  in  1  raw entry loop detector, async; 2-FF synchronised inside
- entry_is_uni  in  1  badge reader at entry, 1 = university car; sampled at debounce completion
- entry_pass  in  1  raw entry barrier pass sensor, async; synchronised
- exit_sensor  in  1  raw exit loop detector, async; synchronised
- exit_is_uni  in  1  badge reader at exit; sampled at debounce completion
- exit_pass  in  1  raw exit barrier pass sensor, async; synchronised
- uni_is_vacated_space  in  1  from park: uni space free
- is_vacated_space  in  1  from park: general space free
- car_entered  out  1  one-cycle pulse per completed entry
- is_uni_car_entered  out  1  class of the last entry; level
- car_exited  out  1  one-cycle pulse per completed exit
- is_uni_car_exited  out  1  class of the last exit; level
- entry_gate_open  out  1  entry barrier drive
- exit_gate_open  out  1  exit barrier drive
- entry_denied  out  1  full indicator for the waiting entry car

Behaviour:
- Reset:
  - All outputs are 0 and both lanes return to IDLE.
  - Synchronisers and counters are cleared.
  - Reset mid-operation closes any open gate immediately and emits no pulse.
- Synchronisation: every sensor passes through 2 FFs. All timing below refers to the synced signals (2-cycle offset from raw).
- Lane FSM states: IDLE, DEBOUNCE, CHECK (entry lane only), OPEN, REPORT, HOLD, DENIED.
- IDLE: sensor high -> DEBOUNCE with counter = 1.
- DEBOUNCE:
  - Sensor low in any cycle -> IDLE.
  - Counter reaches DEBOUNCE_CYCLES -> latch the badge flag. Entry lane goes to CHECK; exit lane goes to OPEN.
- CHECK (one cycle):
  - Vacancy used = latched_uni ? uni_is_vacated_space : is_vacated_space.
  - Vacant -> OPEN; else -> DENIED.
- OPEN:
  - gate_open = 1 and the timer counts from 0.
  - The is_uni_* output is updated to the latched flag on OPEN entry, so it is stable at least 1 cycle before the pulse.
  - Rising edge of pass sensor -> REPORT.
  - Timer reaches OPEN_CYCLES with no pass -> HOLD with no pulse (abandoned car).
- REPORT: car_* = 1 for exactly one cycle; gate_open = 0; -> HOLD.
- HOLD: wait for the loop sensor low, then IDLE. This blocks double counting of one car.
- DENIED: entry_denied = 1 while in the state; -> IDLE when the sensor goes low. The gate never opens. Vacancy reappearing does not reopen; the car must re-trigger.
- is_uni_* flags hold their value until the next OPEN of the same lane.
- Simultaneous REPORT in both lanes in the same cycle:
  - The exit pulse is issued first.
  - The entry lane stalls in REPORT one extra cycle and pulses on the next cycle.
  - car_entered and car_exited are never high in the same cycle.
- Pass sensor high while not in OPEN: ignored.
- Badge flag changes after latching: ignored.
- Counters saturate; widths come from $clog2 of the parameter plus 1.

Decomposition:
- park_pkg holds:
  - lane_state_t enum (IDLE, DEBOUNCE, CHECK, OPEN, REPORT, HOLD, DENIED)
  - default DEBOUNCE_CYCLES / OPEN_CYCLES constants
- Sub-module park_gate_lane is instantiated twice. It contains:
  - the synchronisers and the FSM
  - a parameter HAS_CHECK: 1 for entry, 0 for exit
  - a stall input used for the simultaneous-report arbitration
- park_gate_ctrl is the wrapper: the two lanes plus the arbitration between them.

Test Plan:
- Entry, uni, vacancy present:
  - Stimulus: entry_sensor high 10 cycles, entry_is_uni = 1, uni_is_vacated_space = 1, entry_pass pulsed 5 cycles after the gate opens.
  - Response: entry_gate_open rises 7 cycles after the raw sensor rise. is_uni_car_entered = 1 before the pulse. car_entered is one 1-cycle pulse. Gate closes that cycle.
- Entry, general, full:
  - Stimulus: is_vacated_space = 0.
  - Response: entry_denied = 1 until the sensor drops. No gate open, no car_entered.
- Bounce:
  - Stimulus: entry_sensor high 3 cycles, low, high 3 cycles.
  - Response: no gate open, lane back in IDLE.
- Abandon:
  - Stimulus: gate opens, no pass for 16 cycles.
  - Response: gate closes, no car_entered. The lane re-arms only after the sensor goes low.
- Simultaneous:
  - Stimulus: entry and exit passes aligned to the same REPORT cycle.
  - Response: car_exited at cycle N, car_entered at N+1, never overlapping.
- Reset mid-OPEN:
  - Stimulus: rst = 1 for 1 cycle while exit_gate_open = 1.
  - Response: next cycle all outputs 0. A pass sensor pulse after reset produces no car_exited.
